seq_divider: RTL

- Iterative unsigned divider; the inverse of the team's 32x32 pipelined multiplier. Shares its operand and result conventions: A, B, a half-select s, and a single WIDTH-bit result bus C.
- Computes A / B one quotient bit per clock using restoring division.
- Start/busy/done handshake, so a controller can issue one division at a time.
- Returns the quotient or the remainder on C, selected by s, which is captured at start.

---
 rtl/seq_divider.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, quotient or remainder returned on C.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] C
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     trial;

  // The remainder is always below the divisor, so it is held in WIDTH bits;
  // only the shifted value and the trial subtraction need the extra bit.
  assign accept    = start && (state_q != RUN);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign r_shift   = {r_q, q_q[WIDTH-1]};
  assign trial     = r_shift - {1'b0, b_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a zero divisor skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (B == '0) ? DONE : RUN;
      RUN:  if (last_iter) state_d = DONE;
      DONE: begin
        if (start) state_d = (B == '0) ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Datapath next-state: operand capture, restoring step, result write
  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    b_d   = b_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    dz_d  = dz_q;
    if (accept) begin
      q_d   = A;
      b_d   = B;
      sel_d = s;
      r_d   = '0;
      cnt_d = '0;
      if (B == '0) begin
        c_d  = s ? '1 : A;
        dz_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!trial[WIDTH]) begin
        r_d = trial[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        r_d = r_shift[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
      if (last_iter) begin
        c_d  = sel_q ? q_d : r_d;
        dz_d = 1'b0;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      r_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      cnt_q  <= '0;
      sel_q  <= 1'b0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      b_q    <= b_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign C    = c_q;

endmodule
